// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: button-driven sequential shift-add multiplier with compare flags.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   sw         : [WIDTH-1:0] operand data, [WIDTH] compare enable
//   btn        : raw buttons, [0] load op1, [1] load op2, [2] start
//   led        : compare of new product against previous ({gt, eq, lt})
//   result     : last completed product
//   busy       : multiply in progress (RUN or CMP)
//   done       : one-cycle completion pulse
module mult_seq_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH:0]     sw,
    input  logic [2:0]         btn,
    output logic [2:0]         led,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, CMP} state_t;
    state_t                            r_state;
    logic [SYNC_STAGES-1:0][3:0]       r_sync;
    logic [2:0]                        r_btn_q;
    logic [WIDTH-1:0]                  r_op1, r_op2, r_mplier;
    logic [2*WIDTH-1:0]                r_mcand, r_acc, r_prev;
    logic [CW-1:0]                     r_cnt;
    logic [2:0]                        w_pulse;
    logic                              w_cmp_en;
    // the compare-enable switch rides the same synchronizer as the buttons
    assign w_pulse  = r_sync[SYNC_STAGES-1][2:0] & ~r_btn_q;
    assign w_cmp_en = r_sync[SYNC_STAGES-1][3];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sync   <= '0;
            r_btn_q  <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_prev   <= '0;
            result   <= '0;
            led      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_sync[0] <= {sw[WIDTH], btn};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_btn_q <= r_sync[SYNC_STAGES-1][2:0];
            if (w_pulse[0]) r_op1 <= sw[WIDTH-1:0];
            if (w_pulse[1]) r_op2 <= sw[WIDTH-1:0];
            done <= 1'b0;
            case (r_state)
                IDLE: if (w_pulse[2]) begin
                    r_mcand  <= {{WIDTH{1'b0}}, r_op1};
                    r_mplier <= r_op2;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    busy     <= 1'b1;
                    r_state  <= RUN;
                end
                RUN: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= CMP;
                end
                CMP: begin
                    result  <= r_acc;
                    r_prev  <= r_acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    if (w_cmp_en) led <= {r_acc > r_prev, r_acc == r_prev, r_acc < r_prev};
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
